// File: rtl/adder_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ripple-carry adder,
// one partial product per clock; start/busy/done handshake to the control unit.
module adder_mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_cin,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] hi, lo, mcand;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic [CW-1:0]    count;
   logic             accept, last;

   assign add_cin = 1'b0;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      add_a     = '0;
      add_b     = '0;
      last      = (count == CW'(WIDTH - 1));
      // Carry-out becomes the new MSB of hi; sum LSB shifts into lo as the
      // multiplier bits shift out.
      hi_nxt    = {add_cout, add_sum[WIDTH-1:1]};
      lo_nxt    = {add_sum[0], lo[WIDTH-1:1]};
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            add_a = hi;
            add_b = lo[0] ? mcand : '0;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mcand <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
         end else if (state == RUN) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            count <= count + CW'(1);
            // product only moves on completion so it stays valid through the next op
            if (last) product <= {hi_nxt, lo_nxt};
         end
      end
   end

endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Self-checking bench for adder_mul_sequencer: behavioural adder beside the
// DUT, expected products queued at start and popped at done.
module tb_adder_mul_sequencer;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   multiplicand = '0;
   logic [W-1:0]   multiplier = '0;
   logic           busy, done, add_cin, add_cout;
   logic [2*W-1:0] product;
   logic [W-1:0]   add_a, add_b, add_sum;
   logic [W:0]     add_full;

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] sb[$];
   logic           mon_en = 1'b0;

   always #5 clk = ~clk;

   adder_mul_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // the shared adder the sequencer drives
   assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
   assign add_sum  = add_full[W-1:0];
   assign add_cout = add_full[W];

   // cycle-by-cycle invariants
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (add_cin !== 1'b0) begin
            errors++;
            $display("FAIL add_cin: got %b want 0 at %0t", add_cin, $time);
         end
         checks++;
         if (busy === 1'b1 && done === 1'b1) begin
            errors++;
            $display("FAIL busy_done_excl: both high at %0t", $time);
         end
         if (busy !== 1'b1) begin
            checks++;
            if (add_a !== '0 || add_b !== '0) begin
               errors++;
               $display("FAIL idle_adder: add_a=%h add_b=%h want 0 at %0t", add_a, add_b, $time);
            end
         end
      end
   end

   // Drive start so it is sampled at the next edge; returns just after that edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      start = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts negedges until done (bounded); cyc is the cycle index of done.
   task automatic wait_done(output int cyc, output int busy_cyc, output bit addb_nz, output bit timeout);
      cyc = 0; busy_cyc = 0; addb_nz = 0; timeout = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (busy === 1'b1) begin
            busy_cyc++;
            if (add_b !== '0) addb_nz = 1;
         end
         if (done === 1'b1) begin
            timeout = 0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b product=%h add_a=%h add_b=%h cin=%b want all 0",
                  busy, done, product, add_a, add_b, add_cin);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit chk_addb);
      int cyc, bcyc;
      bit nz, to;
      logic [2*W-1:0] exp;
      sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
      start_op(a, b);
      wait_done(cyc, bcyc, nz, to);
      exp = sb.pop_front();
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s_timeout: no done within 100 cycles", name);
      end
      checks++;
      if (cyc != W + 1 || bcyc != W) begin
         errors++;
         $display("FAIL %s_latency: done at cycle %0d busy %0d cycles, want %0d and %0d", name, cyc, bcyc, W + 1, W);
      end
      checks++;
      if (product !== exp) begin
         errors++;
         $display("FAIL %s_product: got %h want %h", name, product, exp);
      end
      if (chk_addb) begin
         checks++;
         if (nz) begin
            errors++;
            $display("FAIL %s_addb_zero: add_b nonzero during RUN", name);
         end
      end
   endtask

   task automatic test_basic;
      run_and_check("basic_3x5", 32'd3, 32'd5, 0);
      checks++;
      if (product !== 64'h0000_0000_0000_000F) begin
         errors++;
         $display("FAIL basic_const: got %h want 000000000000000f", product);
      end
   endtask

   task automatic test_carry;
      run_and_check("carry_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      checks++;
      if (product !== 64'hFFFF_FFFE_0000_0001) begin
         errors++;
         $display("FAIL carry_const: got %h want fffffffe00000001", product);
      end
   endtask

   task automatic test_zeros;
      run_and_check("zero_mcand", 32'd0, 32'h1234_5678, 1);
      run_and_check("times_one", 32'h1234_5678, 32'd1, 0);
      checks++;
      if (product !== 64'h0000_0000_1234_5678) begin
         errors++;
         $display("FAIL times_one_const: got %h want 0000000012345678", product);
      end
   endtask

   task automatic test_start_while_busy;
      int cyc, bcyc;
      bit nz, to;
      logic [2*W-1:0] exp;
      sb.push_back(64'd63);
      start_op(32'd7, 32'd9);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, bcyc, nz, to);
      exp = sb.pop_front();
      checks++;
      if (to || cyc != W - 9) begin
         errors++;
         $display("FAIL busy_start_latency: done at cycle %0d after ignored start, want %0d (timeout=%0b)", cyc, W - 9, to);
      end
      checks++;
      if (product !== exp) begin
         errors++;
         $display("FAIL busy_start_product: got %h want %h", product, exp);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd63) begin
            errors++;
            $display("FAIL busy_start_no_second: busy=%b done=%b product=%h want 0 0 3f", busy, done, product);
         end
      end
   endtask

   task automatic test_back_to_back;
      int cyc, bcyc;
      bit nz, to;
      logic [2*W-1:0] exp;
      sb.push_back(64'd16);
      start_op(32'd4, 32'd4);
      wait_done(cyc, bcyc, nz, to);
      exp = sb.pop_front();
      checks++;
      if (to || product !== exp) begin
         errors++;
         $display("FAIL b2b_first: got %h want %h (timeout=%0b)", product, exp, to);
      end
      // still in the DONE cycle: request the next op right here
      start = 1'b1; multiplicand = 32'd6; multiplier = 32'd7;
      sb.push_back(64'd42);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || product !== 64'd16) begin
            errors++;
            $display("FAIL b2b_hold: cycle %0d busy=%b product=%h want 1 and 10", i, busy, product);
         end
      end
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (done !== 1'b1 || product !== exp) begin
         errors++;
         $display("FAIL b2b_second: done=%b product=%h want 1 and %h", done, product, exp);
      end
   endtask

   task automatic test_reset_mid_run;
      int seen;
      start_op(32'd5, 32'd5);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      mon_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: busy/done seen %0d cycles want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_zeros();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
      mon_en = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
